// File: rtl/reset_sequencer.sv
// Power-on / system-reset sequencer: power-up delay, reset pulse, user hold and
// config-change triggered resets, with a latched reset cause.
module reset_sequencer #(
    parameter int               NCFG = 3,
    parameter logic [NCFG-1:0]  MASK = '1,
    parameter int               PWW  = 4,
    parameter int               RSW  = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ce,
    input  logic [NCFG-1:0] cfg,
    input  logic            rstReq,
    output logic            power,
    output logic            run,
    output logic [NCFG-1:0] cfgChg,
    output logic [2:0]      cause
);

    typedef enum logic [1:0] {
        PWR  = 2'd0,
        RST  = 2'd1,
        RUN  = 2'd2,
        HOLD = 2'd3
    } state_t;

    localparam logic [PWW-1:0] PW_MAX = '1;
    localparam logic [RSW-1:0] RS_MAX = '1;

    state_t          state, state_n;
    logic [PWW-1:0]  pw, pw_n;
    logic [RSW-1:0]  rs, rs_n;
    logic [NCFG-1:0] cfg_d, cfg_d_n;
    logic [NCFG-1:0] chg;
    logic [NCFG-1:0] cfgchg_n;
    logic [2:0]      cause_n;
    logic            power_n, run_n;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= PWR;
            pw     <= '0;
            rs     <= '0;
            cfg_d  <= '0;
            power  <= 1'b0;
            run    <= 1'b0;
            cfgChg <= '0;
            cause  <= 3'b001;
        end else begin
            state  <= state_n;
            pw     <= pw_n;
            rs     <= rs_n;
            cfg_d  <= cfg_d_n;
            power  <= power_n;
            run    <= run_n;
            cfgChg <= cfgchg_n;
            cause  <= cause_n;
        end
    end

    // Only masked bits that actually moved on an enabled tick count as a change
    assign chg = ce ? ((cfg ^ cfg_d) & MASK) : '0;

    always_comb begin
        state_n  = state;
        pw_n     = pw;
        rs_n     = rs;
        cfg_d_n  = ce ? cfg : cfg_d;
        cfgchg_n = cfgChg;
        cause_n  = cause;

        case (state)
            PWR: begin
                if (ce) begin
                    if (pw == PW_MAX) begin
                        state_n = RST;
                        rs_n    = '0;
                    end else begin
                        pw_n = pw + 1'b1;
                    end
                end
            end
            RST: begin
                // A change during the pulse restarts it rather than ending it
                if (chg != '0) begin
                    rs_n        = '0;
                    cfgchg_n    = cfgChg | chg;
                    cause_n[2]  = 1'b1;
                end else if (ce) begin
                    if (rs == RS_MAX) begin
                        if (rstReq) begin
                            state_n = HOLD;
                            rs_n    = '0;
                        end else begin
                            state_n = RUN;
                        end
                    end else begin
                        rs_n = rs + 1'b1;
                    end
                end
            end
            RUN: begin
                if (ce && rstReq) begin
                    state_n  = HOLD;
                    rs_n     = '0;
                    cause_n  = 3'b010;
                    cfgchg_n = '0;
                end else if (chg != '0) begin
                    state_n  = RST;
                    rs_n     = '0;
                    cause_n  = 3'b100;
                    cfgchg_n = chg;
                end
            end
            HOLD: begin
                rs_n = '0;
                if (chg != '0) begin
                    cfgchg_n   = cfgChg | chg;
                    cause_n[2] = 1'b1;
                end
                if (ce && !rstReq) begin
                    state_n = RST;
                end
            end
            default: begin
                state_n = PWR;
            end
        endcase

        power_n = power | (state_n != PWR);
        run_n   = (state_n == RUN);
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: power-up timing, config-change resets,
// masking, user hold, asynchronous reset and clock-enable throttling.
module tb_reset_sequencer;

    logic       clock;
    logic       reset;
    logic       ce;
    logic [2:0] cfg;
    logic       rstReq;
    logic       power, run;
    logic [2:0] cfgChg, cause;
    logic       power2, run2;
    logic [2:0] cfgChg2, cause2;

    int checks = 0;
    int errors = 0;

    reset_sequencer #(.NCFG(3), .MASK(3'b111), .PWW(4), .RSW(5)) dut (
        .clock(clock), .reset(reset), .ce(ce), .cfg(cfg), .rstReq(rstReq),
        .power(power), .run(run), .cfgChg(cfgChg), .cause(cause)
    );

    reset_sequencer #(.NCFG(3), .MASK(3'b011), .PWW(4), .RSW(5)) dut2 (
        .clock(clock), .reset(reset), .ce(ce), .cfg(cfg), .rstReq(rstReq),
        .power(power2), .run(run2), .cfgChg(cfgChg2), .cause(cause2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; ce = 1'b1; cfg = 3'b000; rstReq = 1'b0;
        tick(2);
        checks++; if (power !== 1'b0) begin errors++; $display("FAIL rst_power: got %b expected 0", power); end
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL rst_run: got %b expected 0", run); end
        checks++; if (cause !== 3'b001) begin errors++; $display("FAIL rst_cause: got %b expected 001", cause); end
        checks++; if (cfgChg !== 3'b000) begin errors++; $display("FAIL rst_cfgchg: got %b expected 000", cfgChg); end
        reset = 1'b1;
        tick(15);
        checks++; if (power !== 1'b0) begin errors++; $display("FAIL pwr_early: got %b expected 0", power); end
        tick(1);
        checks++; if (power !== 1'b1) begin errors++; $display("FAIL pwr_at16: got %b expected 1", power); end
        tick(31);
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL run_at47: got %b expected 0", run); end
        tick(1);
        checks++; if (run !== 1'b1) begin errors++; $display("FAIL run_at48: got %b expected 1", run); end
        checks++; if (cause !== 3'b001) begin errors++; $display("FAIL pwrup_cause: got %b expected 001", cause); end
        checks++; if (run2 !== 1'b1) begin errors++; $display("FAIL run2_at48: got %b expected 1", run2); end
    endtask

    task automatic test_cfg_change();
        cfg = 3'b010;
        tick(1);
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL chg_run_fall: got %b expected 0", run); end
        checks++; if (cfgChg !== 3'b010) begin errors++; $display("FAIL chg_cfgchg: got %b expected 010", cfgChg); end
        checks++; if (cause !== 3'b100) begin errors++; $display("FAIL chg_cause: got %b expected 100", cause); end
        checks++; if (power !== 1'b1) begin errors++; $display("FAIL chg_power: got %b expected 1", power); end
        tick(31);
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL chg_run31: got %b expected 0", run); end
        tick(1);
        checks++; if (run !== 1'b1) begin errors++; $display("FAIL chg_run32: got %b expected 1", run); end
    endtask

    task automatic test_restart();
        cfg = cfg ^ 3'b010;
        tick(1);
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL rs_run_fall: got %b expected 0", run); end
        tick(9);
        cfg = cfg ^ 3'b001;
        tick(1);
        checks++; if (cfgChg !== 3'b011) begin errors++; $display("FAIL rs_cfgchg: got %b expected 011", cfgChg); end
        tick(22);
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL rs_not_early: got %b expected 0", run); end
        tick(9);
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL rs_run31: got %b expected 0", run); end
        tick(1);
        checks++; if (run !== 1'b1) begin errors++; $display("FAIL rs_run32: got %b expected 1", run); end
        checks++; if (cause !== 3'b100) begin errors++; $display("FAIL rs_cause: got %b expected 100", cause); end
    endtask

    task automatic test_mask();
        cfg = cfg ^ 3'b100;
        tick(1);
        checks++; if (run2 !== 1'b1) begin errors++; $display("FAIL mask_run2: got %b expected 1", run2); end
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL mask_run_unmasked: got %b expected 0", run); end
        checks++; if (cfgChg !== 3'b100) begin errors++; $display("FAIL mask_cfgchg_unmasked: got %b expected 100", cfgChg); end
        tick(4);
        checks++; if (run2 !== 1'b1) begin errors++; $display("FAIL mask_run2_later: got %b expected 1", run2); end
        checks++; if (cause2 !== 3'b100) begin errors++; $display("FAIL mask_cause2: got %b expected 100", cause2); end
        checks++; if (cfgChg2 !== 3'b011) begin errors++; $display("FAIL mask_cfgchg2: got %b expected 011", cfgChg2); end
        tick(28);
        checks++; if (run !== 1'b1) begin errors++; $display("FAIL mask_run_back: got %b expected 1", run); end
    endtask

    task automatic test_req();
        int bad;
        rstReq = 1'b1;
        cfg = cfg ^ 3'b010;
        tick(1);
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL req_run_fall: got %b expected 0", run); end
        checks++; if (cause !== 3'b010) begin errors++; $display("FAIL req_cause: got %b expected 010", cause); end
        checks++; if (cfgChg !== 3'b000) begin errors++; $display("FAIL req_cfgchg: got %b expected 000", cfgChg); end
        checks++; if (run2 !== 1'b0) begin errors++; $display("FAIL req_run2: got %b expected 0", run2); end
        bad = 0;
        for (int i = 0; i < 99; i++) begin
            tick(1);
            if (run !== 1'b0) bad++;
        end
        rstReq = 1'b0;
        for (int i = 0; i < 32; i++) begin
            tick(1);
            if (run !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL req_run_low: got %0d high cycles expected 0", bad); end
        tick(1);
        checks++; if (run !== 1'b1) begin errors++; $display("FAIL req_run_back: got %b expected 1", run); end
        checks++; if (cause !== 3'b010) begin errors++; $display("FAIL req_cause_end: got %b expected 010", cause); end
    endtask

    task automatic test_req_hold_end();
        rstReq = 1'b1;
        tick(1);
        rstReq = 1'b0;
        tick(1);
        tick(10);
        rstReq = 1'b1;
        tick(22);
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL hold_end_run: got %b expected 0", run); end
        tick(5);
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL hold_end_stay: got %b expected 0", run); end
        rstReq = 1'b0;
        tick(32);
        checks++; if (run !== 1'b0) begin errors++; $display("FAIL hold_end_run31: got %b expected 0", run); end
        tick(1);
        checks++; if (run !== 1'b1) begin errors++; $display("FAIL hold_end_run32: got %b expected 1", run); end
    endtask

    task automatic test_async_reset();
        reset = 1'b0;
        #1;
        checks++; if (power !== 1'b0 || run !== 1'b0) begin errors++; $display("FAIL arst_run_pwr: got %b%b expected 00", power, run); end
        checks++; if (cause !== 3'b001) begin errors++; $display("FAIL arst_cause: got %b expected 001", cause); end
        checks++; if (cfgChg !== 3'b000) begin errors++; $display("FAIL arst_cfgchg: got %b expected 000", cfgChg); end
        reset = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            ce = (i % 2 == 0);
            tick(1);
            if (i == 31) begin
                checks++; if (power !== 1'b0) begin errors++; $display("FAIL half_pwr31: got %b expected 0", power); end
            end
            if (i == 32) begin
                checks++; if (power !== 1'b1) begin errors++; $display("FAIL half_pwr32: got %b expected 1", power); end
            end
        end
        reset = 1'b0;
        #1;
        checks++; if (power !== 1'b0) begin errors++; $display("FAIL arst_rst_power: got %b expected 0", power); end
        reset = 1'b1;
        for (int i = 1; i <= 96; i++) begin
            ce = (i % 2 == 0);
            tick(1);
            if (i == 95) begin
                checks++; if (run !== 1'b0) begin errors++; $display("FAIL half_run95: got %b expected 0", run); end
            end
            if (i == 96) begin
                checks++; if (run !== 1'b1) begin errors++; $display("FAIL half_run96: got %b expected 1", run); end
                checks++; if (cause !== 3'b001) begin errors++; $display("FAIL half_cause: got %b expected 001", cause); end
            end
        end
    endtask

    task automatic test_ce_low();
        ce = 1'b0;
        cfg = cfg ^ 3'b001;
        rstReq = 1'b1;
        tick(20);
        checks++; if (run !== 1'b1 || power !== 1'b1) begin errors++; $display("FAIL ce_low_hold: got %b%b expected 11", power, run); end
        checks++; if (cause !== 3'b001) begin errors++; $display("FAIL ce_low_cause: got %b expected 001", cause); end
    endtask

    initial begin
        test_reset();
        test_cfg_change();
        test_restart();
        test_mask();
        test_req();
        test_req_hold_end();
        test_async_reset();
        test_ce_low();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
